// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle.
// Carries the instruction-memory request/response channel, the branch
// redirect from downstream, and the valid/ready instruction channel to decode.
//   master : the fetch queue itself (drives requests and the decode channel)
//   slave  : the environment (instruction memory, branch unit, decode)
// Signals:
//   imem_req_valid/addr/ready  fetch request handshake, byte address
//   imem_rsp_valid/data        in-order instruction word returns
//   redirect_valid/pc          taken branch, restart fetch at redirect_pc
//   inst_valid/inst/inst_pc    queue head presented to decode
//   inst_ready                 decode consumes the head this cycle
interface fetch_queue_if #(
  parameter int N = 64
);
  logic          imem_req_valid;
  logic [N-1:0]  imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          redirect_valid;
  logic [N-1:0]  redirect_pc;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [N-1:0]  inst_pc;
  logic          inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// LEGv8 instruction fetch queue.
// Holds the fetch PC, issues pipelined word requests to instruction memory,
// buffers returned words in a DEPTH-entry queue and presents them to decode.
// A branch redirect restarts fetch and flushes queued and in-flight words.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears all state in one cycle
//   bus    fetch_queue_if.master (memory request/response, redirect, decode)
// Parameters:
//   N        PC/address width
//   DEPTH    instruction queue entries (power of two, >= 2)
//   RESET_PC fetch address after reset
module fetch_queue #(
  parameter int           N        = 64,
  parameter int           DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef logic [CW-1:0] cnt_t;

  logic [N-1:0]  r_pc;
  cnt_t          r_count;
  cnt_t          r_out;
  cnt_t          r_drop;

  // Instruction queue (word + its address)
  logic [31:0]   r_q_inst [DEPTH];
  logic [N-1:0]  r_q_pc   [DEPTH];
  logic [AW-1:0] r_q_head;
  logic [AW-1:0] r_q_tail;

  // Addresses of requests in flight, in issue order
  logic [N-1:0]  r_pf     [DEPTH];
  logic [AW-1:0] r_pf_head;
  logic [AW-1:0] r_pf_tail;

  logic [CW:0]   w_inflight;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_fire;
  logic          w_rsp_keep;
  logic          w_pop;
  cnt_t          w_out_next;

  // Credit rule: queued plus in-flight words never exceed the queue size,
  // so every response is guaranteed a free slot.
  assign w_inflight  = {1'b0, r_count} + {1'b0, r_out};
  assign w_req_valid = !reset && !bus.redirect_valid && (w_inflight < DEPTH_C);
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp_fire  = bus.imem_rsp_valid && (r_out != '0);
  // Responses are discarded while stale ones drain, and in a redirect cycle.
  assign w_rsp_keep  = w_rsp_fire && (r_drop == '0) && !bus.redirect_valid;
  assign w_pop       = (r_count != '0) && bus.inst_ready;
  assign w_out_next  = r_out + cnt_t'(w_req_fire) - cnt_t'(w_rsp_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_count   <= '0;
      r_out     <= '0;
      r_drop    <= '0;
      r_q_head  <= '0;
      r_q_tail  <= '0;
      r_pf_head <= '0;
      r_pf_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
        r_pf[i]     <= '0;
      end
    end else begin
      if (w_req_fire) begin
        r_pc             <= r_pc + N'(4);
        r_pf[r_pf_tail]  <= r_pc;
        r_pf_tail        <= r_pf_tail + AW'(1);
      end
      // Dropped responses still pop their address so pairing stays aligned.
      if (w_rsp_fire) begin
        r_pf_head <= r_pf_head + AW'(1);
      end
      r_out <= w_out_next;

      if (bus.redirect_valid) begin
        // No request fires in a redirect cycle, so this pc write is exclusive.
        r_pc     <= bus.redirect_pc & ~N'(3);
        r_drop   <= w_out_next;
        r_count  <= '0;
        r_q_head <= '0;
        r_q_tail <= '0;
      end else begin
        if (w_rsp_fire && (r_drop != '0)) begin
          r_drop <= r_drop - cnt_t'(1);
        end
        if (w_rsp_keep) begin
          r_q_inst[r_q_tail] <= bus.imem_rsp_data;
          r_q_pc[r_q_tail]   <= r_pf[r_pf_head];
          r_q_tail           <= r_q_tail + AW'(1);
        end
        if (w_pop) begin
          r_q_head <= r_q_head + AW'(1);
        end
        r_count <= r_count + cnt_t'(w_rsp_keep) - cnt_t'(w_pop);
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = (r_count != '0);
  assign bus.inst           = r_q_inst[r_q_head];
  assign bus.inst_pc        = r_q_pc[r_q_head];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int N     = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.N(N)) bus();

  fetch_queue #(.N(N), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] addr;
    int           due;
  } mreq_t;

  mreq_t        mq[$];   // memory model: accepted requests awaiting response
  logic [N-1:0] sb[$];   // scoreboard: addresses decode must receive, in order

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int lat   = 1;
  int n_acc = 0;

  logic         st_reset, st_req_ready, st_inst_ready, st_redir;
  logic [N-1:0] st_redir_pc;
  logic [N-1:0] exp_pc;
  logic [N-1:0] last_acc_addr;
  logic [N-1:0] want_first_pc;
  bit           want_first;
  logic         last_req_valid, last_inst_valid;
  logic [31:0]  last_inst;
  logic [N-1:0] last_inst_pc;

  function automatic logic [31:0] mem_word(input logic [N-1:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, sample settled outputs, advance the clock.
  task automatic step();
    reset              = st_reset;
    bus.imem_req_ready = st_req_ready;
    bus.inst_ready     = st_inst_ready;
    bus.redirect_valid = st_redir;
    bus.redirect_pc    = st_redir_pc;
    if (!st_reset && mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    #2;
    last_req_valid  = bus.imem_req_valid;
    last_inst_valid = bus.inst_valid;
    last_inst       = bus.inst;
    last_inst_pc    = bus.inst_pc;
    if (st_reset) begin
      mq.delete();
      sb.delete();
      exp_pc     = '0;
      want_first = 1'b0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", bus.imem_req_addr, exp_pc);
        mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
        sb.push_back(bus.imem_req_addr);
        last_acc_addr = bus.imem_req_addr;
        exp_pc        = exp_pc + 64'd4;
        n_acc++;
      end
      if (bus.inst_valid && bus.inst_ready) begin
        if (sb.size() == 0) begin
          chk("stale_inst_pc", bus.inst_pc, ~bus.inst_pc);
        end else begin
          logic [N-1:0] e;
          e = sb.pop_front();
          chk("inst_pc", bus.inst_pc, e);
          chk("inst", 64'(bus.inst), 64'(mem_word(e)));
          if (want_first) begin
            chk("redir_first_pc", bus.inst_pc, want_first_pc);
            want_first = 1'b0;
          end
        end
      end
      if (st_redir) begin
        sb.delete();
        exp_pc        = st_redir_pc & ~64'd3;
        want_first    = 1'b1;
        want_first_pc = exp_pc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    st_reset      = 1'b1;
    st_inst_ready = 1'b0;
    st_req_ready  = 1'b1;
    st_redir      = 1'b0;
    st_redir_pc   = '0;
    repeat (n) step();
    st_reset = 1'b0;
    n_acc    = 0;
  endtask

  initial begin
    st_reset = 1'b1; st_req_ready = 1'b1; st_inst_ready = 1'b0;
    st_redir = 1'b0; st_redir_pc = '0; exp_pc = '0; last_acc_addr = '0;
    want_first = 1'b0; want_first_pc = '0;

    // Reset state
    lat = 1;
    do_reset(3);
    chk("rst_req_valid", 64'(last_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(last_inst_valid), 64'd0);
    chk("rst_inst", 64'(last_inst), 64'd0);
    chk("rst_inst_pc", last_inst_pc, 64'd0);

    // Zero-wait memory, decode always ready
    st_inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) chk("t1_first_req", last_acc_addr, 64'h0);
      if (i >= 2) chk("t1_valid_cont", 64'(last_inst_valid), 64'd1);
      else        chk("t1_valid_early", 64'(last_inst_valid), 64'd0);
    end

    // Stall: queue fills to DEPTH, then drains in order
    do_reset(2);
    lat = 1;
    repeat (10) step();
    chk("t2_acc_cnt", 64'(n_acc), 64'd4);
    chk("t2_req_stopped", 64'(last_req_valid), 64'd0);
    chk("t2_full_valid", 64'(last_inst_valid), 64'd1);
    st_inst_ready = 1'b1;
    step();
    chk("t2_no_req_on_pop", 64'(last_req_valid), 64'd0);
    step();
    chk("t2_resume_req", 64'(last_req_valid), 64'd1);
    chk("t2_resume_addr", last_acc_addr, 64'h10);
    repeat (10) step();

    // Redirect with three requests outstanding, latency 3
    do_reset(2);
    lat = 3;
    st_inst_ready = 1'b1;
    repeat (3) step();
    st_redir = 1'b1; st_redir_pc = 64'h100;
    step();
    chk("t3_no_req_redir", 64'(last_req_valid), 64'd0);
    st_redir = 1'b0;
    step();
    chk("t3_new_addr", last_acc_addr, 64'h100);
    repeat (12) step();
    chk("t3_first_seen", 64'(want_first), 64'd0);

    // Redirect to an unaligned target in the same cycle as a response
    do_reset(2);
    lat = 1;
    st_inst_ready = 1'b1;
    repeat (2) step();
    st_redir = 1'b1; st_redir_pc = 64'h203;
    step();
    st_redir = 1'b0;
    step();
    chk("t4_aligned_addr", last_acc_addr, 64'h200);
    repeat (8) step();
    chk("t4_first_seen", 64'(want_first), 64'd0);

    // Request-ready toggling, irregular decode backpressure
    do_reset(2);
    lat = 2;
    for (int i = 0; i < 24; i++) begin
      st_req_ready  = (i % 2 == 0);
      st_inst_ready = (i % 3 != 0);
      step();
    end
    st_req_ready  = 1'b0;
    st_inst_ready = 1'b1;
    repeat (10) step();
    chk("t5_drained", 64'(sb.size()), 64'd0);
    chk("t5_accepts", 64'(n_acc > 8), 64'd1);
    st_req_ready = 1'b1;

    // Reset mid-stream with the queue full
    do_reset(2);
    lat = 1;
    repeat (8) step();
    chk("t6_full_valid", 64'(last_inst_valid), 64'd1);
    chk("t6_full_noreq", 64'(last_req_valid), 64'd0);
    do_reset(1);
    st_inst_ready = 1'b0;
    step();
    chk("t6_post_valid", 64'(last_inst_valid), 64'd0);
    chk("t6_post_inst", 64'(last_inst), 64'd0);
    chk("t6_post_req", 64'(last_req_valid), 64'd1);
    chk("t6_post_addr", last_acc_addr, 64'h0);
    repeat (6) step();
    chk("t6_acc_cnt", 64'(n_acc), 64'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
